// File: rtl/tick_timer.sv
// Programmable down-counting timer driven by a periodic tick enable.
// Periodic / one-shot modes, auto-reload, sticky W1C flag and level irq.
module tick_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_LOAD   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  reg_sel_e         sel;
  logic             unused_addr_bits;

  logic             en_q, oneshot_q, ie_q, if_q;
  logic [WIDTH-1:0] load_q, count_q;

  logic             en_d, oneshot_d, ie_d, if_d;
  logic [WIDTH-1:0] load_d, count_d, rdata_d;

  logic             wr_ctrl, wr_load, wr_count, wr_status;
  logic             en_rise, count_tick, expire;

  assign sel              = reg_sel_e'(addr[3:2]);
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    wr_ctrl   = wr_en && (sel == REG_CTRL);
    wr_load   = wr_en && (sel == REG_LOAD);
    wr_count  = wr_en && (sel == REG_COUNT);
    wr_status = wr_en && (sel == REG_STATUS);

    en_rise    = wr_ctrl && !en_q && wdata[0];
    // A tick is lost to a COUNT write, or to a CTRL write that leaves EN low.
    count_tick = tick && en_q && !wr_count && !(wr_ctrl && !wdata[0]);
    expire     = count_tick && (count_q == '0);

    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
    if_d      = if_q;
    load_d    = load_q;
    count_d   = count_q;

    if (count_tick) begin
      if (expire) begin
        if_d = 1'b1;
        if (oneshot_q) en_d = 1'b0;
        else           count_d = load_q;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end

    if (wr_status && wdata[0] && !expire) if_d = 1'b0;

    // Later assignments take priority: software writes override the counter.
    if (wr_ctrl) begin
      en_d      = wdata[0];
      oneshot_d = wdata[1];
      ie_d      = wdata[2];
    end
    if (en_rise)  count_d = load_q;
    if (wr_load)  load_d  = wdata;
    if (wr_count) count_d = wdata;

    rdata_d = '0;
    if (rd_en) begin
      case (sel)
        REG_CTRL:   rdata_d[2:0] = {ie_q, oneshot_q, en_q};
        REG_LOAD:   rdata_d      = load_q;
        REG_COUNT:  rdata_d      = count_q;
        REG_STATUS: rdata_d[0]   = if_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      ie_q      <= 1'b0;
      if_q      <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      rdata     <= '0;
      irq       <= 1'b0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      if_q      <= if_d;
      load_q    <= load_d;
      count_q   <= count_d;
      rdata     <= rdata_d;
      irq       <= if_d & ie_d;
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus randomized
// traffic compared against a register-level behavioural model.
module tb_tick_timer;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [3:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (register view as seen by software)
  logic             m_en, m_os, m_ie, m_if, m_irq;
  logic [WIDTH-1:0] m_load, m_count, m_rdata;

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_if = 0; m_irq = 0;
    m_load = '0; m_count = '0; m_rdata = '0;
  endtask

  task automatic model_step(input logic tk, input logic w, input logic r,
                            input logic [3:0] a, input logic [WIDTH-1:0] d);
    logic [1:0]       s;
    logic             ctrl_w, use_tick;
    logic             n_en, n_os, n_ie, n_if;
    logic [WIDTH-1:0] n_load, n_count;
    s = a[3:2];
    n_en = m_en; n_os = m_os; n_ie = m_ie; n_if = m_if;
    n_load = m_load; n_count = m_count;
    m_rdata = '0;
    if (r) begin
      if (s == 0)      m_rdata = {29'd0, m_ie, m_os, m_en};
      else if (s == 1) m_rdata = m_load;
      else if (s == 2) m_rdata = m_count;
      else             m_rdata = {31'd0, m_if};
    end
    ctrl_w   = w && (s == 0);
    use_tick = tk && m_en && !(w && s == 2) && !(ctrl_w && !d[0]);
    if (w && s == 3 && d[0]) n_if = 0;
    if (use_tick) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        n_if = 1;
        if (m_os) n_en = 0;
        else      n_count = m_load;
      end
    end
    if (ctrl_w) begin
      n_en = d[0]; n_os = d[1]; n_ie = d[2];
      if (!m_en && d[0]) n_count = m_load;
    end
    if (w && s == 1) n_load = d;
    if (w && s == 2) n_count = d;
    m_en = n_en; m_os = n_os; m_ie = n_ie; m_if = n_if;
    m_load = n_load; m_count = n_count;
    m_irq = n_if & n_ie;
  endtask

  task automatic do_cycle(input logic tk, input logic w, input logic r,
                          input logic [3:0] a, input logic [WIDTH-1:0] d);
    tick = tk; wr_en = w; rd_en = r; addr = a; wdata = d;
    @(posedge clk);
    model_step(tk, w, r, a, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; tick = 0; wr_en = 0; rd_en = 0; addr = '0; wdata = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick = (i % 2 == 0); wr_en = 1; addr = 4'h0; wdata = 32'h7;
      @(posedge clk); #1;
      checks++;
      if (irq !== 1'b0 || rdata !== '0) begin
        errors++; $display("FAIL reset_hold: irq=%b rdata=%0h required 0/0", irq, rdata);
      end
    end
    @(negedge clk);
    tick = 0; wr_en = 0; wdata = '0;
    rst_n = 1;
    for (int unsigned r = 0; r < 4; r++) begin
      do_cycle(0, 0, 1, 4'(r * 4), '0);
      checks++;
      if (rdata !== '0 || irq !== 1'b0) begin
        errors++; $display("FAIL reset_reg%0d: rdata=%0h irq=%b required 0/0", r, rdata, irq);
      end
    end
  endtask

  task automatic test_periodic();
    do_reset();
    do_cycle(0, 1, 0, 4'h4, 3);
    do_cycle(0, 1, 0, 4'h0, 5);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 3) begin errors++; $display("FAIL periodic_start: count=%0d required 3", rdata); end
    for (int k = 1; k <= 12; k++) begin
      do_cycle(1, 0, 0, 0, 0);
      checks++;
      if (irq !== (k % 4 == 0)) begin
        errors++; $display("FAIL periodic_irq_t%0d: irq=%b required %b", k, irq, (k % 4 == 0));
      end
      do_cycle(0, 0, 1, 4'h8, 0);
      checks++;
      if (rdata !== 32'(3 - (k % 4))) begin
        errors++; $display("FAIL periodic_count_t%0d: count=%0d required %0d", k, rdata, 3 - (k % 4));
      end
      if (k % 4 == 0) begin
        do_cycle(0, 1, 0, 4'hC, 1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL periodic_w1c_t%0d: irq=%b required 0", k, irq); end
      end else begin
        do_cycle(0, 0, 0, 0, 0);
      end
      do_cycle(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    do_cycle(0, 1, 0, 4'h4, 2);
    do_cycle(0, 1, 0, 4'h0, 7);
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: irq=%b required 1", irq); end
    do_cycle(0, 0, 1, 4'h0, 0);
    checks++;
    if (rdata !== 6) begin errors++; $display("FAIL oneshot_ctrl: ctrl=%0h required 6", rdata); end
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 0) begin errors++; $display("FAIL oneshot_count: count=%0d required 0", rdata); end
    do_cycle(0, 0, 1, 4'hC, 0);
    checks++;
    if (rdata !== 1) begin errors++; $display("FAIL oneshot_if: status=%0h required 1", rdata); end
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 0) begin errors++; $display("FAIL oneshot_idle_count: count=%0d required 0", rdata); end
    do_cycle(0, 0, 1, 4'h0, 0);
    checks++;
    if (rdata !== 6) begin errors++; $display("FAIL oneshot_idle_ctrl: ctrl=%0h required 6", rdata); end
  endtask

  task automatic test_w1c_collision();
    do_reset();
    do_cycle(0, 1, 0, 4'h0, 5);
    do_cycle(1, 0, 0, 0, 0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_first_expiry: irq=%b required 1", irq); end
    do_cycle(1, 1, 0, 4'hC, 1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_collision_irq: irq=%b required 1", irq); end
    do_cycle(0, 0, 1, 4'hC, 0);
    checks++;
    if (rdata !== 1) begin errors++; $display("FAIL w1c_collision_if: status=%0h required 1", rdata); end
    do_cycle(0, 1, 0, 4'hC, 0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_write0: irq=%b required 1", irq); end
    do_cycle(0, 1, 0, 4'hC, 1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: irq=%b required 0", irq); end
  endtask

  task automatic test_count_collision();
    do_reset();
    do_cycle(0, 1, 0, 4'h4, 20);
    do_cycle(0, 1, 0, 4'h0, 1);
    do_cycle(0, 1, 0, 4'h8, 5);
    do_cycle(1, 1, 0, 4'h8, 9);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 9) begin errors++; $display("FAIL count_write_wins: count=%0d required 9", rdata); end
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 8) begin errors++; $display("FAIL count_after_tick: count=%0d required 8", rdata); end
    do_cycle(1, 1, 0, 4'h0, 0);
    do_cycle(1, 1, 0, 4'h4, 3);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 8) begin errors++; $display("FAIL ctrl_disable_tick: count=%0d required 8", rdata); end
    do_cycle(1, 1, 0, 4'h0, 1);
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 3) begin errors++; $display("FAIL enable_edge_load: count=%0d required 3", rdata); end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_cycle(0, 1, 0, 4'h4, 10);
    do_cycle(0, 1, 0, 4'h0, 5);
    do_cycle(0, 1, 0, 4'h8, 0);
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 9 || irq !== 1'b1) begin
      errors++; $display("FAIL async_pre: count=%0d irq=%b required 9/1", rdata, irq);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rdata !== '0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_immediate: rdata=%0h irq=%b required 0/0", rdata, irq);
    end
    tick = 0; rd_en = 0;
    @(negedge clk) rst_n = 1;
    do_cycle(0, 0, 1, 4'h8, 0);
    checks++;
    if (rdata !== 0) begin errors++; $display("FAIL async_count: count=%0d required 0", rdata); end
    do_cycle(0, 0, 1, 4'h0, 0);
    checks++;
    if (rdata !== 0) begin errors++; $display("FAIL async_ctrl: ctrl=%0h required 0", rdata); end
  endtask

  task automatic test_random();
    logic             tk, w, r;
    logic [3:0]       a;
    logic [WIDTH-1:0] d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(0, 5) == 0);
      r  = $urandom_range(0, 1);
      a  = 4'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      do_cycle(tk, w, r, a, d);
      checks++;
      if (rdata !== m_rdata || irq !== m_irq) begin
        errors++;
        $display("FAIL random_c%0d: rdata=%0h irq=%b required %0h/%b", i, rdata, irq, m_rdata, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c_collision();
    test_count_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
